// File: rtl/flu_wb_arbiter_pkg.sv
// flu_wb_arbiter_pkg: shared types for the execute-stage writeback arbiter
package flu_wb_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int TRANS_ID_BITS = 3;
  typedef enum logic {WB_ARB_RR = 1'b0, WB_ARB_FIXED = 1'b1} wb_arb_mode_e;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic ex_valid;
    logic [XLEN-1:0] ex_cause;
  } flu_wb_entry_t;
endpackage

// File: rtl/flu_wb_arbiter_if.sv
// flu_wb_arbiter_if: producer channels plus the scoreboard writeback port
interface flu_wb_arbiter_if #(
  parameter int NrChannels = 3,
  parameter int DataWidth = 64,
  parameter int TransIdWidth = 3,
  parameter int CauseWidth = 64
);
  localparam int IdxW = NrChannels > 1 ? $clog2(NrChannels) : 1;
  logic [NrChannels-1:0] ch_valid_i;
  logic [NrChannels-1:0] ch_ready_o;
  logic [NrChannels-1:0][DataWidth-1:0] ch_result_i;
  logic [NrChannels-1:0][TransIdWidth-1:0] ch_trans_id_i;
  logic [NrChannels-1:0] ch_ex_valid_i;
  logic [NrChannels-1:0][CauseWidth-1:0] ch_ex_cause_i;
  logic wb_valid_o;
  logic wb_ready_i;
  logic [DataWidth-1:0] wb_result_o;
  logic [TransIdWidth-1:0] wb_trans_id_o;
  logic wb_ex_valid_o;
  logic [CauseWidth-1:0] wb_ex_cause_o;
  logic [IdxW-1:0] wb_channel_o;
  logic conflict_o;
  modport slave (
    input ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_valid_i, ch_ex_cause_i, wb_ready_i,
    output ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o,
    wb_channel_o, conflict_o
  );
  modport master (
    output ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_valid_i, ch_ex_cause_i, wb_ready_i,
    input ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o,
    wb_channel_o, conflict_o
  );
endinterface

// File: rtl/flu_wb_arbiter_fifo.sv
// flu_wb_fifo: one channel's circular buffer with a zero-latency fall-through head
module flu_wb_fifo
  import flu_wb_arbiter_pkg::*;
#(
  parameter int Depth = 2,
  parameter type entry_t = flu_wb_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t data_i,
  output logic   full_o,
  output logic   head_valid_o,
  output entry_t head_o,
  input  logic   pop_i
);
  localparam int PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  entry_t r_mem [Depth];
  logic [PtrW-1:0] r_wr, r_rd;
  logic [CntW-1:0] r_cnt;
  logic w_empty, w_wr, w_rd;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_empty = r_cnt == '0;
  assign full_o = r_cnt == CntW'(Depth);
  assign head_valid_o = !w_empty || push_i;
  assign head_o = w_empty ? data_i : r_mem[r_rd];
  // an input consumed in the same cycle it arrives never touches storage
  assign w_wr = push_i && !flush_i && !(w_empty && pop_i);
  assign w_rd = pop_i && !flush_i && !w_empty;
  always_ff @(posedge clk_i) if (w_wr) r_mem[r_wr] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= nxt(r_wr);
      if (w_rd) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CntW'(w_wr) - CntW'(w_rd);
    end
endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: merges buffered functional-unit results onto one writeback port
module flu_wb_arbiter
  import flu_wb_arbiter_pkg::*;
#(
  parameter int NrChannels = 3,
  parameter int Depth = 2,
  parameter int DataWidth = 64,
  parameter int TransIdWidth = 3,
  parameter int CauseWidth = 64,
  parameter wb_arb_mode_e ArbMode = WB_ARB_RR
) (
  input logic clk_i,
  input logic rst_ni,
  input logic flush_i,
  flu_wb_arbiter_if.slave bus
);
  localparam int IdxW = NrChannels > 1 ? $clog2(NrChannels) : 1;
  typedef struct packed {
    logic [DataWidth-1:0] result;
    logic [TransIdWidth-1:0] trans_id;
    logic ex_valid;
    logic [CauseWidth-1:0] ex_cause;
  } entry_t;
  entry_t [NrChannels-1:0] w_in, w_head;
  logic [NrChannels-1:0] w_h, w_full, w_pop;
  logic [IdxW-1:0] r_rr, w_gnt;
  logic w_valid, w_hs;
  function automatic logic [IdxW-1:0] rot(input logic [IdxW-1:0] base, input int k);
    return IdxW'(ArbMode == WB_ARB_FIXED ? k : (int'(base) + k) % NrChannels);
  endfunction
  for (genvar i = 0; i < NrChannels; i++) begin : g_ch
    assign w_in[i] = {bus.ch_result_i[i], bus.ch_trans_id_i[i], bus.ch_ex_valid_i[i], bus.ch_ex_cause_i[i]};
    assign w_pop[i] = w_hs && w_gnt == IdxW'(i);
    flu_wb_fifo #(.Depth(Depth), .entry_t(entry_t)) u_fifo (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .flush_i(flush_i),
      .push_i(bus.ch_valid_i[i] && !w_full[i]),
      .data_i(w_in[i]),
      .full_o(w_full[i]),
      .head_valid_o(w_h[i]),
      .head_o(w_head[i]),
      .pop_i(w_pop[i])
    );
  end
  // scan from farthest to nearest so the nearest valid head wins
  always_comb begin
    w_gnt = '0;
    for (int k = NrChannels - 1; k >= 0; k--) w_gnt = w_h[rot(r_rr, k)] ? rot(r_rr, k) : w_gnt;
  end
  assign w_valid = |w_h && !flush_i;
  assign w_hs = w_valid && bus.wb_ready_i;
  assign bus.ch_ready_o = ~w_full;
  assign bus.wb_valid_o = w_valid;
  assign bus.wb_result_o = w_valid ? w_head[w_gnt].result : '0;
  assign bus.wb_trans_id_o = w_valid ? w_head[w_gnt].trans_id : '0;
  assign bus.wb_ex_valid_o = w_valid && w_head[w_gnt].ex_valid;
  assign bus.wb_ex_cause_o = w_valid ? w_head[w_gnt].ex_cause : '0;
  assign bus.wb_channel_o = w_valid ? w_gnt : '0;
  assign bus.conflict_o = $countones(w_h) >= 2 && !flush_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_rr <= '0;
    else if (w_hs && ArbMode == WB_ARB_RR) r_rr <= w_gnt == IdxW'(NrChannels - 1) ? '0 : w_gnt + 1'b1;
endmodule

// File: tb/tb_flu_wb_arbiter.sv
// tb_flu_wb_arbiter: round-robin and fixed-priority instances checked against per-channel queue models
module tb_flu_wb_arbiter;
  import flu_wb_arbiter_pkg::*;
  localparam int N = 3, D = 2, DW = 64, TW = 3, CW = 64;
  typedef struct packed {
    logic [DW-1:0] res;
    logic [TW-1:0] id;
    logic exv;
    logic [CW-1:0] cause;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;
  flu_wb_arbiter_if #(.NrChannels(N), .DataWidth(DW), .TransIdWidth(TW), .CauseWidth(CW)) bus_rr ();
  flu_wb_arbiter_if #(.NrChannels(N), .DataWidth(DW), .TransIdWidth(TW), .CauseWidth(CW)) bus_fx ();
  flu_wb_arbiter #(.NrChannels(N), .Depth(D), .DataWidth(DW), .TransIdWidth(TW), .CauseWidth(CW),
    .ArbMode(WB_ARB_RR)) u_rr (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus_rr.slave));
  flu_wb_arbiter #(.NrChannels(N), .Depth(D), .DataWidth(DW), .TransIdWidth(TW), .CauseWidth(CW),
    .ArbMode(WB_ARB_FIXED)) u_fx (.clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus_fx.slave));
  logic [N-1:0] in_v;
  ent_t in_e [N];
  logic rdy;
  ent_t q [2][N][$];
  int rr [2];
  int checks = 0, errors = 0;

  task automatic apply();
    bus_rr.ch_valid_i = in_v;
    bus_fx.ch_valid_i = in_v;
    bus_rr.wb_ready_i = rdy;
    bus_fx.wb_ready_i = rdy;
    for (int c = 0; c < N; c++) begin
      bus_rr.ch_result_i[c] = in_e[c].res;
      bus_fx.ch_result_i[c] = in_e[c].res;
      bus_rr.ch_trans_id_i[c] = in_e[c].id;
      bus_fx.ch_trans_id_i[c] = in_e[c].id;
      bus_rr.ch_ex_valid_i[c] = in_e[c].exv;
      bus_fx.ch_ex_valid_i[c] = in_e[c].exv;
      bus_rr.ch_ex_cause_i[c] = in_e[c].cause;
      bus_fx.ch_ex_cause_i[c] = in_e[c].cause;
    end
  endtask

  task automatic idle_inputs();
    in_v = '0;
    for (int c = 0; c < N; c++) in_e[c] = '0;
  endtask

  // model arbitration: m=0 round-robin from rr[0], m=1 lowest index first
  function automatic void arb(input int m, output logic v, output int g, output int cnt);
    v = 1'b0;
    g = 0;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      int c = (m == 1) ? k : (rr[m] + k) % N;
      if (q[m][c].size() > 0 || in_v[c]) begin
        cnt++;
        if (!v) begin v = 1'b1; g = c; end
      end
    end
  endfunction

  function automatic ent_t head(input int m, input int c);
    return q[m][c].size() > 0 ? q[m][c][0] : in_e[c];
  endfunction

  task automatic sample(input int m, output logic [138:0] o);
    if (m == 0) o = {bus_rr.wb_valid_o, bus_rr.wb_channel_o, bus_rr.wb_trans_id_o, bus_rr.wb_ex_valid_o,
                     bus_rr.wb_result_o, bus_rr.wb_ex_cause_o, bus_rr.ch_ready_o, bus_rr.conflict_o};
    else o = {bus_fx.wb_valid_o, bus_fx.wb_channel_o, bus_fx.wb_trans_id_o, bus_fx.wb_ex_valid_o,
              bus_fx.wb_result_o, bus_fx.wb_ex_cause_o, bus_fx.ch_ready_o, bus_fx.conflict_o};
  endtask

  task automatic check(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic v;
      int g, cnt;
      ent_t e;
      logic [N-1:0] er;
      logic [138:0] obs, exp;
      arb(m, v, g, cnt);
      v = v && !flush;
      e = v ? head(m, g) : '0;
      for (int c = 0; c < N; c++) er[c] = q[m][c].size() < D;
      exp = {v, v ? 2'(g) : 2'b0, e.id, e.exv, e.res, e.cause, er, cnt >= 2 && !flush};
      sample(m, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s mode=%0d t=%0t got {v,ch,id,exv,res,cause,rdy,cf}=%h expected %h", tag, m, $time, obs, exp);
      end
    end
  endtask

  task automatic update();
    for (int m = 0; m < 2; m++) begin
      logic v;
      int g, cnt;
      if (flush) begin
        for (int c = 0; c < N; c++) q[m][c].delete();
      end else begin
        arb(m, v, g, cnt);
        for (int c = 0; c < N; c++) if (in_v[c] && q[m][c].size() < D) q[m][c].push_back(in_e[c]);
        if (v && rdy) begin
          void'(q[m][g].pop_front());
          if (m == 0) rr[m] = (g + 1) % N;
        end
      end
    end
  endtask

  // one cycle: drive at negedge, compare before the edge, advance model on the edge
  task automatic step(input string tag);
    apply();
    #1 check(tag);
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    logic [138:0] obs;
    for (int m = 0; m < 2; m++) begin
      sample(m, obs);
      checks++;
      if (obs !== {1'b0, 2'b0, 3'b0, 1'b0, 64'b0, 64'b0, 3'b111, 1'b0}) begin
        errors++;
        $display("FAIL %s mode=%0d got %h expected idle reset outputs", tag, m, obs);
      end
    end
  endtask

  function automatic ent_t mk(input logic [DW-1:0] r, input int id);
    return '{res: r, id: TW'(id), exv: 1'b0, cause: '0};
  endfunction

  task automatic test_reset();
    idle_inputs();
    rdy = 1'b1;
    apply();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    step("reset_idle");
  endtask

  task automatic test_passthrough();
    idle_inputs();
    rdy = 1'b1;
    in_v = 3'b001;
    in_e[0] = mk(64'hA5, 2);
    step("passthrough");
    idle_inputs();
    step("passthrough_empty");
  endtask

  task automatic test_rr();
    rdy = 1'b1;
    in_v = 3'b111;
    for (int c = 0; c < N; c++) in_e[c] = mk(64'h100 + 64'(c), c + 1);
    step("rr_conflict");
    idle_inputs();
    repeat (3) step("rr_drain");
  endtask

  task automatic test_backpressure();
    int idx = 0;
    idle_inputs();
    rdy = 1'b0;
    for (int t = 0; t < 5; t++) begin
      bit acc = q[0][1].size() < D;
      in_v = idx < 3 ? 3'b010 : 3'b000;
      in_e[1] = mk(64'h200 + 64'(idx), 4 + idx);
      if (t == 4) rdy = 1'b1;
      step("backpressure");
      if (acc && in_v[1]) idx++;
    end
    in_v = idx < 3 ? 3'b010 : 3'b000;
    in_e[1] = mk(64'h200 + 64'(idx), 4 + idx);
    step("bp_drain");
    idle_inputs();
    repeat (3) step("bp_drain");
  endtask

  task automatic test_fixed();
    idle_inputs();
    rdy = 1'b0;
    in_v = 3'b100;
    for (int t = 0; t < 2; t++) begin
      in_e[2] = mk(64'h300 + 64'(t), t);
      step("fixed_fill");
    end
    rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_v = 3'b001;
      in_e[0] = mk(64'h400 + 64'(t), 5 + t);
      step("fixed_ch0");
    end
    idle_inputs();
    repeat (3) step("fixed_drain");
  endtask

  task automatic test_flush();
    rdy = 1'b0;
    in_v = 3'b111;
    for (int t = 0; t < 2; t++) begin
      for (int c = 0; c < N; c++) in_e[c] = mk(64'h500 + 64'(t * 4 + c), c);
      step("flush_fill");
    end
    flush = 1'b1;
    rdy = 1'b1;
    step("flush_cycle");
    flush = 1'b0;
    idle_inputs();
    step("after_flush");
  endtask

  task automatic test_async_reset();
    rdy = 1'b0;
    in_v = 3'b111;
    for (int c = 0; c < N; c++) in_e[c] = mk(64'h600 + 64'(c), c + 2);
    repeat (2) step("ar_fill");
    rdy = 1'b1;
    idle_inputs();
    step("ar_drain");
    apply();
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    for (int m = 0; m < 2; m++) begin
      rr[m] = 0;
      for (int c = 0; c < N; c++) q[m][c].delete();
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    repeat (2) step("after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      in_v = N'($urandom);
      for (int c = 0; c < N; c++)
        in_e[c] = '{res: {$urandom, $urandom}, id: TW'($urandom), exv: 1'($urandom), cause: {$urandom, $urandom}};
      rdy = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      step("random");
    end
    flush = 1'b0;
    idle_inputs();
    rdy = 1'b1;
    repeat (8) step("random_drain");
  endtask

  initial begin
    rr[0] = 0;
    rr[1] = 0;
    test_reset();
    test_passthrough();
    test_rr();
    test_backpressure();
    test_fixed();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
